// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Instruction-fetch control FSM. On a FETCH request in IDLE it holds a
//   memory read request (M_REQ, M_ADDR = PC) until the memory acknowledges,
//   a jump aborts the fetch, or TIMEOUT cycles pass without an acknowledge
//   (FAULT). An acknowledged word is strobed into the external instruction
//   storage register with MIS, then IR_VALID pulses for one cycle and the
//   PC advances by one.
//
// Parameters
//   RESET_PC  PC value after reset
//   TIMEOUT   WAIT cycles without M_ACK before FAULT (1..255)
//
// Ports
//   CLK       rising-edge clock
//   CLR       asynchronous active-high reset
//   FETCH     request one fetch (sampled in IDLE only)
//   JMP       load PC from JMP_ADDR; aborts an in-flight fetch
//   JMP_ADDR  jump target
//   M_ACK     memory read complete (data valid on the memory bus this cycle)
//   M_REQ     memory read request
//   M_ADDR    read address (always the PC)
//   MIS       load strobe for the instruction storage register
//   IR_VALID  one-cycle pulse: instruction register holds a new word
//   PC_OUT    current PC
//   BUSY      state is not IDLE
//   FAULT     fetch timed out; waiting for JMP or CLR
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        FETCH,
    input  logic        JMP,
    input  logic [15:0] JMP_ADDR,
    input  logic        M_ACK,
    output logic        M_REQ,
    output logic [15:0] M_ADDR,
    output logic        MIS,
    output logic        IR_VALID,
    output logic [15:0] PC_OUT,
    output logic        BUSY,
    output logic        FAULT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Last counter value that may still see an acknowledge before faulting.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] pc;
    logic [7:0]  wait_cnt;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            wait_cnt <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A jump in the same cycle as FETCH wins; the fetch is dropped.
                    if (JMP) begin
                        pc <= JMP_ADDR;
                    end else if (FETCH) begin
                        state    <= S_WAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (JMP) begin
                        pc    <= JMP_ADDR;
                        state <= S_IDLE;
                    end else if (M_ACK) begin
                        pc    <= pc + 16'd1;
                        state <= S_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (JMP) begin
                        pc <= JMP_ADDR;
                    end
                    state <= S_IDLE;
                end
                S_FAULT: begin
                    if (JMP) begin
                        pc    <= JMP_ADDR;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status outputs are pure decodes of the state register, so they follow
    // the asynchronous reset immediately and never depend on inputs.
    assign M_REQ    = (state == S_WAIT);
    assign IR_VALID = (state == S_DONE);
    assign BUSY     = (state != S_IDLE);
    assign FAULT    = (state == S_FAULT);
    assign M_ADDR   = pc;
    assign PC_OUT   = pc;

    // MIS is combinational so the storage register captures the bus on the
    // same edge that ends the acknowledge cycle. A jump discards the word,
    // and CLR is gated in directly so the strobe drops without waiting for
    // the state register.
    assign MIS = (state == S_WAIT) & M_ACK & ~JMP & ~CLR;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, program-counter value after reset.
REQ-002 Parameter TIMEOUT, default 15, max WAIT-state cycles without M_ACK before fault; legal range 1..255.
REQ-003 The clock/reset scheme SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 CLR  input  1  asynchronous active-high reset.
REQ-006 FETCH  input  1  request one instruction fetch; sampled only in IDLE.
REQ-007 JMP  input  1  load PC from JMP_ADDR; aborts an in-flight fetch.
REQ-008 JMP_ADDR  input  16  jump target.
REQ-009 M_ACK  input  1  memory read complete; M_BUS valid in the same cycle.
REQ-010 M_REQ  output  1  memory read request.
REQ-011 M_ADDR  output  16  read address, equals PC.
REQ-012 MIS  output  1  load strobe to instruction storage register; it captures M_BUS on the edge ending the MIS cycle.
REQ-013 IR_VALID  output  1  one-cycle pulse: instruction register holds a new word.
REQ-014 PC_OUT  output  16  current PC.
REQ-015 BUSY  output  1  high whenever state is not IDLE.
REQ-016 FAULT  output  1  high in FAULT state.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, DONE, FAULT.
REQ-018 IDLE: M_REQ=0, MIS=0; JMP -> PC<=JMP_ADDR, stay IDLE; else FETCH -> WAIT, wait counter<=0; JMP beats FETCH in the same cycle.
REQ-019 WAIT: M_REQ=1, M_ADDR=PC every cycle until exit; M_ADDR SHALL not change while M_REQ is high.
REQ-020 WAIT with M_ACK=1 and JMP=0: MIS=1 combinationally that cycle; next edge PC<=PC+1 (16-bit, 16'hFFFF wraps to 16'h0000), state -> DONE.
REQ-021 WAIT with M_ACK=0: wait counter increments; when counter == TIMEOUT-1 and no ACK, next state -> FAULT, PC unchanged.
REQ-022 WAIT with JMP=1: MIS SHALL be 0 that cycle even if M_ACK=1; next edge PC<=JMP_ADDR, state -> IDLE; the ACKed word is discarded.
REQ-023 DONE: IR_VALID=1 for exactly one cycle, M_REQ=0, FETCH ignored; JMP -> PC<=JMP_ADDR; next state IDLE unconditionally.
REQ-024 Minimum fetch latency: FETCH in cycle n, M_ACK in n+1 -> MIS in n+1, IR_VALID in n+2, next FETCH accepted in n+3.
REQ-025 FAULT: FAULT=1, M_REQ=0, MIS=0; FETCH ignored; only JMP (PC<=JMP_ADDR, -> IDLE) or CLR exits.
REQ-026 M_ACK outside WAIT SHALL be ignored (no MIS, no PC change).
REQ-027 MIS SHALL be asserted at most once per accepted FETCH.
REQ-028 Wait counter width SHALL be 8 bits; it resets to 0 on every WAIT entry.

Reset
REQ-029 CLR=1 SHALL immediately, without a clock edge, force state=IDLE, PC=RESET_PC, wait counter=0, M_REQ=0, MIS=0, IR_VALID=0, BUSY=0, FAULT=0, M_ADDR=PC_OUT=RESET_PC.
REQ-030 CLR asserted mid-WAIT SHALL drop M_REQ asynchronously and suppress MIS even if M_ACK is high.
REQ-031 After CLR deasserts, the first FETCH is accepted on the first rising edge with CLR=0.

Verification
REQ-032 Reset, FETCH pulse, M_ACK two cycles later with M_BUS=16'hA5C3 -> M_ADDR=0000 during WAIT, one MIS cycle, ISR=A5C3, IR_VALID one cycle later, PC_OUT=0001.
REQ-033 PC=16'hFFFF, fetch with immediate ACK -> MIS pulse, PC_OUT=16'h0000 after edge.
REQ-034 FETCH, M_ACK held low, TIMEOUT=15 -> M_REQ high exactly 15 cycles, then FAULT=1, M_REQ=0; further FETCH ignored; JMP with JMP_ADDR=16'h0100 -> IDLE, FAULT=0, PC_OUT=0100.
REQ-035 In WAIT, JMP=1 and M_ACK=1 same cycle, JMP_ADDR=16'h2000 -> MIS stays 0, no IR_VALID, PC_OUT=2000, BUSY=0 next cycle.
REQ-036 CLR pulse (not edge-aligned) during WAIT with M_ACK=1 -> M_REQ and MIS drop within the same cycle, PC_OUT=RESET_PC, no IR_VALID.
REQ-037 FETCH held high continuously with ACK one cycle after each request -> MIS every third cycle, PC increments by one per fetch, no double MIS.
